// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, TX FSM state encodings and divisor floor.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_PARITY = 3'd4;
    localparam logic [2:0] ST_STOP   = 3'd5;

    localparam int unsigned MIN_DIV = 2;

    // Mode 11 is reserved and behaves as no parity.
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: latches a clamped divisor on load and ticks on the last cycle of each bit.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick_c
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt;

    assign tick_c = en && (cnt == div_q - DIV_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            cnt   <= '0;
        end else if (load) begin
            div_q <= (div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : div;
            cnt   <= '0;
        end else if (en) begin
            cnt <= tick_c ? '0 : cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter draining a non-show-ahead FIFO onto a single TX pin.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic [1:0]        parity_mode,
    input  logic              stop2,
    input  logic              empty,
    input  logic [DATA_W-1:0] data,
    output logic              rd_en,
    output logic              txd,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [2:0]        state, state_nxt;
    logic [DATA_W-1:0] sh, sh_nxt;
    logic [BIT_W-1:0]  bit_idx, bit_idx_nxt;
    logic              stop_idx, stop_idx_nxt;
    logic              par_bit, par_bit_nxt;
    logic [1:0]        mode_q, mode_nxt;
    logic              stop2_q, stop2_nxt;
    logic              txd_nxt, busy_nxt, frame_done_nxt;
    logic              tick_c, baud_load_c, baud_en_c;

    assign baud_load_c = (state == ST_LOAD);
    assign baud_en_c   = (state != ST_IDLE) && (state != ST_LOAD);

    uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
        .clk    (clk),
        .rst    (rst),
        .load   (baud_load_c),
        .en     (baud_en_c),
        .div    (baud_div),
        .tick_c (tick_c)
    );

    // Next-state decode; txd_nxt is the level for the state being entered.
    always_comb begin
        state_nxt      = state;
        sh_nxt         = sh;
        bit_idx_nxt    = bit_idx;
        stop_idx_nxt   = stop_idx;
        par_bit_nxt    = par_bit;
        mode_nxt       = mode_q;
        stop2_nxt      = stop2_q;
        txd_nxt        = txd;
        frame_done_nxt = 1'b0;
        rd_en          = 1'b0;

        case (state)
            ST_IDLE: begin
                txd_nxt = 1'b1;
                if (!empty) begin
                    rd_en     = !rst;
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                sh_nxt       = data;
                mode_nxt     = parity_mode;
                stop2_nxt    = stop2;
                par_bit_nxt  = (parity_mode == PAR_ODD) ? ~(^data) : ^data;
                bit_idx_nxt  = '0;
                stop_idx_nxt = 1'b0;
                txd_nxt      = 1'b0;
                state_nxt    = ST_START;
            end
            ST_START: begin
                if (tick_c) begin
                    txd_nxt     = sh[0];
                    sh_nxt      = sh >> 1;
                    bit_idx_nxt = '0;
                    state_nxt   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick_c) begin
                    if (bit_idx == BIT_W'(DATA_W - 1)) begin
                        if (parity_enabled(mode_q)) begin
                            txd_nxt   = par_bit;
                            state_nxt = ST_PARITY;
                        end else begin
                            txd_nxt      = 1'b1;
                            stop_idx_nxt = 1'b0;
                            state_nxt    = ST_STOP;
                        end
                    end else begin
                        txd_nxt     = sh[0];
                        sh_nxt      = sh >> 1;
                        bit_idx_nxt = bit_idx + BIT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (tick_c) begin
                    txd_nxt      = 1'b1;
                    stop_idx_nxt = 1'b0;
                    state_nxt    = ST_STOP;
                end
            end
            ST_STOP: begin
                txd_nxt = 1'b1;
                if (tick_c) begin
                    if (stop2_q && !stop_idx) begin
                        stop_idx_nxt = 1'b1;
                    end else begin
                        frame_done_nxt = 1'b1;
                        stop_idx_nxt   = 1'b0;
                        if (!empty) begin
                            rd_en     = !rst;
                            state_nxt = ST_LOAD;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end
                end
            end
            default: begin
                txd_nxt   = 1'b1;
                state_nxt = ST_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            sh         <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            par_bit    <= 1'b0;
            mode_q     <= PAR_NONE;
            stop2_q    <= 1'b0;
            txd        <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            sh         <= sh_nxt;
            bit_idx    <= bit_idx_nxt;
            stop_idx   <= stop_idx_nxt;
            par_bit    <= par_bit_nxt;
            mode_q     <= mode_nxt;
            stop2_q    <= stop2_nxt;
            txd        <= txd_nxt;
            busy       <= busy_nxt;
            frame_done <= frame_done_nxt;
        end
    end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter that drains bytes from a standard (non-show-ahead) FIFO and serialises them onto a single TX line. Supports the following:
- 5–9 data bits.
- Runtime-programmable baud divisor.
- Optional even/odd parity.
- One or two stop bits.

It sits between the TX FIFO and the board pin and replaces the fixed 8N1 transmitter in new designs.

## Interface
- DATA_W, 8, data bits per frame; legal range 5..9.
- DIV_W, 16, width of the baud divisor.
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- baud_div  in  DIV_W  clock cycles per bit; values 0 and 1 are treated as 2.
- parity_mode  in  2  selects parity:
  - 00 = none.
  - 01 = even.
  - 10 = odd.
  - 11 = none.
- stop2  in  1  0 = one stop bit, 1 = two stop bits.
- empty  in  1  FIFO empty flag.
- data  in  DATA_W  FIFO read data; valid the cycle after rd_en.
- rd_en  out  1  FIFO read strobe; one-cycle pulse, combinational decode of state, bit counters and empty.
- txd  out  1  serial output; registered; idle high.
- busy  out  1  registered; high from LOAD through the end of the last stop bit.
- frame_done  out  1  registered one-cycle pulse in the cycle after the final stop bit completes.

## Operation
- FSM states: IDLE, LOAD, START, DATA, PARITY, STOP.
- IDLE:
  - txd = 1.
  - If empty = 0: rd_en = 1 this cycle, next state LOAD.
- LOAD (one cycle):
  - Capture the FIFO word into the shift register.
  - Latch the effective baud_div (clamped to ≥2), parity_mode and stop2 into shadow registers.
  - Compute the parity bit:
    - Even parity bit = XOR of all data bits.
    - Odd parity bit = XNOR of all data bits.
  - txd stays 1.
  - Next state START.
- START: txd = 0 for div cycles.
- DATA:
  - DATA_W bits, LSB first, div cycles each.
  - Bit index counter runs 0..DATA_W-1.
- PARITY:
  - Present only if the shadow parity mode is 01 or 10.
  - Lasts div cycles.
- STOP:
  - txd = 1 for div cycles; two such periods if shadow stop2 = 1.
  - In the final cycle of the last stop period:
    - If empty = 0: rd_en = 1, next state LOAD.
    - Otherwise: next state IDLE.
- Config inputs changing mid-frame have no effect until the next LOAD.
- empty falling mid-frame is ignored until the final stop cycle.
- The baud counter is DIV_W bits, counts 0..div-1 and wraps to 0 at each bit boundary. No overflow is possible because div ≤ 2^DIV_W-1.
- Reset mid-frame:
  - Next edge forces IDLE and txd = 1; the frame is abandoned.
  - rd_en is 0 while rst = 1.
  - The FIFO word already read is discarded.

## Timing
- Reset values:
  - txd = 1, busy = 0, frame_done = 0, rd_en = 0.
  - All counters and the shift register are 0.
- Latency: rd_en at cycle T; data sampled at T+1 (LOAD); txd falls at edge T+2.
- Frame length in cycles = div × (1 + DATA_W + P + S), with P ∈ {0,1} and S ∈ {1,2}.
- Back-to-back frames: exactly one extra high cycle (LOAD) between the last stop bit and the next start bit.
- frame_done pulses in the cycle following the final stop cycle.
  - When chaining, it coincides with LOAD of the next frame.
- busy remains 1 across chained frames.

## Structure
- Shared package uart_pkg:
  - Parity mode constants PAR_NONE/PAR_EVEN/PAR_ODD.
  - State enum for the TX FSM.
  - Minimum divisor constant (2).
- Sub-module uart_baud_gen:
  - DIV_W-bit counter with load/clear.
  - Emits a tick on the last cycle of each bit period.
  - Reusable by the future receiver.
- Top level holds the FSM, shift register, bit counter and parity logic.

## Test plan
- Basic frame:
  - Stimulus: DATA_W=8, div=4, parity none, stop2=0, FIFO holds 0xA5.
  - Response: one rd_en pulse; txd = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (40 cycles); frame_done once; busy falls afterwards.
- Parity, two stop bits:
  - Stimulus: div=4, even parity, stop2=1, data 0x07.
  - Response: parity bit 1, two stop periods, 48-cycle frame.
  - Repeat with odd parity: parity bit 0.
- Back-to-back:
  - Stimulus: FIFO holds 0x55 and 0x0F.
  - Response: second rd_en in the final stop cycle of frame 1; one-cycle high gap; second frame correct; busy stays 1 throughout.
- Mid-frame config change:
  - Stimulus: baud_div 4→8 and parity none→odd during data bits of frame 1.
  - Response: frame 1 keeps div=4 and no parity; frame 2 uses div=8 with odd parity.
- Divisor clamp:
  - Stimulus: baud_div=1, then baud_div=0.
  - Response: each bit lasts 2 cycles.
- Reset mid-frame:
  - Stimulus: rst=1 for one cycle during data bit 3, with empty=0 throughout.
  - Response:
    - txd = 1 at the next edge and rd_en = 0 during reset.
    - A fresh frame starts with rd_en the cycle after rst deasserts.
    - No frame_done for the aborted frame.
